// File: rtl/grf_write_scheduler.sv
// grf_write_scheduler: owns the single GRF write port and arbitrates between the
// in-order W stage and buffered long-latency (mul/div) results. It also keeps a
// per-register pending scoreboard so the D stage stalls on outstanding LLU writes.
// Optional build macro: GRF_WRITE_TRACE_EN prints one line per committed GRF write.
module grf_write_scheduler #(
  parameter int unsigned FIFO_DEPTH   = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  // W stage write
  input  logic        wb_valid_i,
  input  logic [4:0]  wb_addr_i,
  input  logic [31:0] wb_data_i,
  input  logic [31:0] wb_pc_i,
  output logic        wb_ready_o,
  // LLU destination reservation
  input  logic        rsv_valid_i,
  input  logic [4:0]  rsv_addr_i,
  output logic        rsv_ready_o,
  // LLU result
  input  logic        ll_valid_i,
  input  logic [4:0]  ll_addr_i,
  input  logic [31:0] ll_data_i,
  input  logic [31:0] ll_pc_i,
  output logic        ll_ready_o,
  // D stage hazard query
  input  logic [4:0]  d_rs_i,
  input  logic [4:0]  d_rt_i,
  input  logic [4:0]  d_rd_i,
  output logic        d_stall_o,
  // GRF write port
  output logic        rf_we_o,
  output logic [4:0]  rf_a3_o,
  output logic [31:0] rf_wd_o,
  output logic [31:0] rf_pc_o
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
    logic [31:0] pc;
  } wr_req_t;

  // Scoreboard and arbitration state
  logic [31:0]   pending_q, pending_d;
  logic [SW-1:0] starve_cnt_q, starve_cnt_d;

  // LLU result FIFO
  wr_req_t       fifo_mem_q [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;

  // Registered GRF port
  logic          rf_we_q;
  logic [4:0]    rf_a3_q;
  logic [31:0]   rf_wd_q;
  logic [31:0]   rf_pc_q;

  logic          fifo_empty;
  logic          starve_full;
  logic          w_win;
  logic          h_win;
  logic          push;
  logic          pop;
  wr_req_t       head;
  wr_req_t       ll_req;

  // Handshakes, hazard detection and arbitration decision
  always_comb begin
    fifo_empty  = (count_q == '0);
    starve_full = (starve_cnt_q == SW'(STARVE_LIMIT));
    // ll_ready uses the registered count only; a pop this cycle does not free a slot
    ll_ready_o  = (count_q != CW'(FIFO_DEPTH));
    // W is only held off when the LLU head has already lost STARVE_LIMIT times
    wb_ready_o  = !(starve_full && !fifo_empty);
    rsv_ready_o = !pending_q[rsv_addr_i];
    d_stall_o   = pending_q[d_rs_i] | pending_q[d_rt_i] | pending_q[d_rd_i];
    w_win       = wb_valid_i && wb_ready_o;
    h_win       = !w_win && !fifo_empty;
    push        = ll_valid_i && ll_ready_o;
    pop         = h_win;
    head        = fifo_mem_q[rd_ptr_q];
    ll_req      = '{addr: ll_addr_i, data: ll_data_i, pc: ll_pc_i};
  end

  // Next-state for scoreboard, starvation counter and FIFO bookkeeping
  always_comb begin
    pending_d    = pending_q;
    starve_cnt_d = starve_cnt_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    count_d      = count_q;

    // Clear is applied after set so a same-register collision keeps the bit clear
    if (rsv_valid_i && rsv_ready_o) begin
      pending_d[rsv_addr_i] = 1'b1;
    end
    if (pop) begin
      pending_d[head.addr] = 1'b0;
    end
    pending_d[0] = 1'b0;

    if (fifo_empty || h_win) begin
      starve_cnt_d = '0;
    end else if (w_win && !starve_full) begin
      starve_cnt_d = starve_cnt_q + SW'(1);
    end

    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    count_d = count_q + CW'(push) - CW'(pop);
  end

  // Control state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q    <= '0;
      starve_cnt_q <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      pending_q    <= pending_d;
      starve_cnt_q <= starve_cnt_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
    end
  end

  // FIFO storage; contents are don't-care while count is zero
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem_q[wr_ptr_q] <= ll_req;
    end
  end

  // GRF port registers load from the arbitration winner; $0 is consumed without a write
  always_ff @(posedge clk) begin
    if (reset) begin
      rf_we_q <= 1'b0;
      rf_a3_q <= '0;
      rf_wd_q <= '0;
      rf_pc_q <= '0;
    end else if (w_win) begin
      rf_we_q <= (wb_addr_i != 5'd0);
      rf_a3_q <= wb_addr_i;
      rf_wd_q <= wb_data_i;
      rf_pc_q <= wb_pc_i;
    end else if (h_win) begin
      rf_we_q <= (head.addr != 5'd0);
      rf_a3_q <= head.addr;
      rf_wd_q <= head.data;
      rf_pc_q <= head.pc;
    end else begin
      rf_we_q <= 1'b0;
    end
  end

  assign rf_we_o = rf_we_q;
  assign rf_a3_o = rf_a3_q;
  assign rf_wd_o = rf_wd_q;
  assign rf_pc_o = rf_pc_q;

`ifdef GRF_WRITE_TRACE_EN
  // Commit trace, one line per real GRF write in commit order
  always_ff @(posedge clk) begin
    if (rf_we_q && (rf_a3_q != 5'd0)) begin
      $display("%d@%h: $%d <= %h", $time, rf_pc_q, rf_a3_q, rf_wd_q);
    end
  end
`endif

endmodule

// File: tb/tb_grf_write_scheduler.sv
// Directed bench for grf_write_scheduler with hand-computed expectations.
module tb_grf_write_scheduler;

  logic        clk;
  logic        reset;
  logic        wb_valid;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic [31:0] wb_pc;
  logic        wb_ready;
  logic        rsv_valid;
  logic [4:0]  rsv_addr;
  logic        rsv_ready;
  logic        ll_valid;
  logic [4:0]  ll_addr;
  logic [31:0] ll_data;
  logic [31:0] ll_pc;
  logic        ll_ready;
  logic [4:0]  d_rs;
  logic [4:0]  d_rt;
  logic [4:0]  d_rd;
  logic        d_stall;
  logic        rf_we;
  logic [4:0]  rf_a3;
  logic [31:0] rf_wd;
  logic [31:0] rf_pc;

  int n_vec;
  int n_err;

  // Expected per-cycle values for the streaming/FIFO-fill sequence
  logic       exp_wr [17];
  logic       exp_lr [17];
  logic [4:0] exp_a3 [17];

  grf_write_scheduler #(.FIFO_DEPTH(2), .STARVE_LIMIT(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .wb_valid_i  (wb_valid),
    .wb_addr_i   (wb_addr),
    .wb_data_i   (wb_data),
    .wb_pc_i     (wb_pc),
    .wb_ready_o  (wb_ready),
    .rsv_valid_i (rsv_valid),
    .rsv_addr_i  (rsv_addr),
    .rsv_ready_o (rsv_ready),
    .ll_valid_i  (ll_valid),
    .ll_addr_i   (ll_addr),
    .ll_data_i   (ll_data),
    .ll_pc_i     (ll_pc),
    .ll_ready_o  (ll_ready),
    .d_rs_i      (d_rs),
    .d_rt_i      (d_rt),
    .d_rd_i      (d_rd),
    .d_stall_o   (d_stall),
    .rf_we_o     (rf_we),
    .rf_a3_o     (rf_a3),
    .rf_wd_o     (rf_wd),
    .rf_pc_o     (rf_pc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wb_valid  = 1'b0; wb_addr = '0; wb_data = '0; wb_pc = '0;
    rsv_valid = 1'b0; rsv_addr = '0;
    ll_valid  = 1'b0; ll_addr = '0; ll_data = '0; ll_pc = '0;
    d_rs = '0; d_rt = '0; d_rd = '0;
  endtask

  initial begin
    int w_idx;
    int l_idx;
    logic [31:0] exp_wd;

    n_vec = 0;
    n_err = 0;
    exp_wr = '{1,1,1,1,1,0,1,1,1,1,0,1,1,1,1,0,1};
    exp_lr = '{1,1,0,0,0,0,1,0,0,0,0,1,1,1,1,1,1};
    exp_a3 = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd21, 5'd6, 5'd7, 5'd8, 5'd9,
               5'd22, 5'd10, 5'd11, 5'd12, 5'd13, 5'd23, 5'd14};

    // Reset state
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    check_eq("rst_we", 32'(rf_we), 32'd0);
    check_eq("rst_a3", 32'(rf_a3), 32'd0);
    check_eq("rst_wd", rf_wd, 32'd0);
    check_eq("rst_pc", rf_pc, 32'd0);
    reset = 1'b0;
    #1;
    check_eq("rst_wb_ready", 32'(wb_ready), 32'd1);
    check_eq("rst_ll_ready", 32'(ll_ready), 32'd1);
    check_eq("rst_d_stall", 32'(d_stall), 32'd0);
    check_eq("rst_rsv_ready", 32'(rsv_ready), 32'd1);

    // Plain W write, visible on the GRF port one cycle later
    wb_valid = 1'b1; wb_addr = 5'd8; wb_data = 32'h1234; wb_pc = 32'h3000;
    #1;
    check_eq("w_ready", 32'(wb_ready), 32'd1);
    tick();
    wb_valid = 1'b0;
    check_eq("w_we", 32'(rf_we), 32'd1);
    check_eq("w_a3", 32'(rf_a3), 32'd8);
    check_eq("w_wd", rf_wd, 32'h1234);
    check_eq("w_pc", rf_pc, 32'h3000);
    tick();
    check_eq("w_we_drop", 32'(rf_we), 32'd0);

    // Reservations and stall
    rsv_valid = 1'b1; rsv_addr = 5'd9;
    #1;
    check_eq("rsv9_ready", 32'(rsv_ready), 32'd1);
    tick();
    check_eq("rsv9_dup_ready", 32'(rsv_ready), 32'd0);
    rsv_addr = 5'd0;
    #1;
    check_eq("rsv0_ready", 32'(rsv_ready), 32'd1);
    tick();
    rsv_valid = 1'b0;
    d_rs = 5'd0;
    #1;
    check_eq("stall_rs0", 32'(d_stall), 32'd0);
    d_rs = 5'd9;
    #1;
    check_eq("stall_rs9", 32'(d_stall), 32'd1);
    d_rs = 5'd0; d_rt = 5'd9;
    #1;
    check_eq("stall_rt9", 32'(d_stall), 32'd1);
    d_rt = 5'd0; d_rd = 5'd9;
    #1;
    check_eq("stall_rd9", 32'(d_stall), 32'd1);
    d_rd = 5'd0; d_rs = 5'd9;

    // LLU result with W idle: written two cycles after ll_valid
    ll_valid = 1'b1; ll_addr = 5'd9; ll_data = 32'hABCD; ll_pc = 32'h3008;
    #1;
    check_eq("ll9_ready", 32'(ll_ready), 32'd1);
    tick();
    ll_valid = 1'b0;
    #1;
    check_eq("ll9_lat1_we", 32'(rf_we), 32'd0);
    check_eq("ll9_lat1_stall", 32'(d_stall), 32'd1);
    tick();
    check_eq("ll9_we", 32'(rf_we), 32'd1);
    check_eq("ll9_a3", 32'(rf_a3), 32'd9);
    check_eq("ll9_wd", rf_wd, 32'hABCD);
    check_eq("ll9_pc", rf_pc, 32'h3008);
    check_eq("ll9_stall_clear", 32'(d_stall), 32'd0);
    d_rs = 5'd0;
    tick();

    // W streaming while three LLU results arrive: starvation back-pressure and FIFO full
    w_idx = 1;
    l_idx = 21;
    for (int c = 0; c < 17; c++) begin
      wb_valid = 1'b1;
      wb_addr  = 5'(w_idx);
      wb_data  = 32'(32'h100 + w_idx);
      wb_pc    = 32'(32'h4000 + 4 * w_idx);
      ll_valid = (l_idx <= 23);
      ll_addr  = 5'(l_idx);
      ll_data  = 32'(32'hA00 + l_idx);
      ll_pc    = 32'(32'h5000 + 4 * l_idx);
      #1;
      check_eq($sformatf("fill_wb_ready_c%0d", c), 32'(wb_ready), 32'(exp_wr[c]));
      check_eq($sformatf("fill_ll_ready_c%0d", c), 32'(ll_ready), 32'(exp_lr[c]));
      if (wb_ready) w_idx++;
      if (ll_valid && ll_ready) l_idx++;
      tick();
      exp_wd = (exp_a3[c] >= 5'd21) ? 32'(32'hA00 + 32'(exp_a3[c])) : 32'(32'h100 + 32'(exp_a3[c]));
      check_eq($sformatf("fill_we_c%0d", c), 32'(rf_we), 32'd1);
      check_eq($sformatf("fill_a3_c%0d", c), 32'(rf_a3), 32'(exp_a3[c]));
      check_eq($sformatf("fill_wd_c%0d", c), rf_wd, exp_wd);
    end
    idle_inputs();
    tick();
    check_eq("fill_idle_we", 32'(rf_we), 32'd0);

    // Writes to $0 from both producers are consumed without asserting rf_we
    ll_valid = 1'b1; ll_addr = 5'd0; ll_data = 32'hDEAD; ll_pc = 32'h6000;
    tick();
    ll_valid = 1'b0;
    check_eq("z_ll_push_we", 32'(rf_we), 32'd0);
    tick();
    check_eq("z_ll_pop_we", 32'(rf_we), 32'd0);
    check_eq("z_ll_pop_pc_loaded", rf_pc, 32'h6000);
    wb_valid = 1'b1; wb_addr = 5'd0; wb_data = 32'hBEEF; wb_pc = 32'h6004;
    #1;
    check_eq("z_wb_ready", 32'(wb_ready), 32'd1);
    tick();
    wb_valid = 1'b0;
    check_eq("z_wb_we", 32'(rf_we), 32'd0);
    tick();
    check_eq("z_idle_we", 32'(rf_we), 32'd0);

    // Reset with a buffered result: no write afterwards and pending cleared
    rsv_valid = 1'b1; rsv_addr = 5'd12;
    tick();
    rsv_valid = 1'b0;
    ll_valid = 1'b1; ll_addr = 5'd12; ll_data = 32'h77; ll_pc = 32'h7000;
    tick();
    ll_valid = 1'b0;
    reset = 1'b1;
    d_rs = 5'd12;
    #1;
    check_eq("mid_pre_stall", 32'(d_stall), 32'd1);
    tick();
    reset = 1'b0;
    #1;
    check_eq("mid_rst_we", 32'(rf_we), 32'd0);
    check_eq("mid_rst_stall", 32'(d_stall), 32'd0);
    check_eq("mid_rst_ll_ready", 32'(ll_ready), 32'd1);
    rsv_addr = 5'd12;
    #1;
    check_eq("mid_rst_rsv_ready", 32'(rsv_ready), 32'd1);
    tick();
    check_eq("mid_post1_we", 32'(rf_we), 32'd0);
    tick();
    check_eq("mid_post2_we", 32'(rf_we), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
